pipe_chain: RTL and testbench

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_chain.sv | 103 ++++++++++
 tb/tb_pipe_chain.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_chain.sv
// pipe_chain: valid/ready pipeline with per-stage stall, range flush and taps.
// Define PIPE_CHAIN_PERF_EN to build the saturating performance counters.
module pipe_chain #(
    parameter int W      = 32,
    parameter int STAGES = 5,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_data,
    input  logic [STAGES-1:0]   stall_req,
    input  logic [STAGES-1:0]   flush_req,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_data,
    output logic [STAGES-1:0]   stage_valid,
    output logic [STAGES*W-1:0] stage_data,
    output logic [CNT_W-1:0]    cnt_retired,
    output logic [CNT_W-1:0]    cnt_bubble,
    output logic [CNT_W-1:0]    cnt_flush
);
    logic [STAGES-1:0] r_valid;
    logic [W-1:0]      r_data [STAGES];
    logic [STAGES-1:0] w_move, w_ready, w_kill, w_cap;
    logic [W-1:0]      w_src  [STAGES];

    // Ready ripples from the oldest stage down so back-pressure costs no cycle;
    // a stalled stage neither accepts nor releases its item.
    always_comb begin
        w_move = '0;
        w_ready = '0;
        w_kill = '0;
        w_cap = '0;
        w_move[STAGES-1] = r_valid[STAGES-1] && out_ready && !stall_req[STAGES-1];
        w_ready[STAGES-1] = !stall_req[STAGES-1] && (!r_valid[STAGES-1] || w_move[STAGES-1]);
        for (int i = STAGES-2; i >= 0; i--) begin
            w_move[i] = r_valid[i] && !stall_req[i] && w_ready[i+1];
            w_ready[i] = !stall_req[i] && (!r_valid[i] || w_move[i]);
        end
        for (int i = 0; i < STAGES; i++)
            w_kill[i] = |(flush_req >> i);
        w_src[0] = in_data;
        w_cap[0] = in_valid && w_ready[0] && !w_kill[0];
        for (int i = 1; i < STAGES; i++) begin
            w_src[i] = r_data[i-1];
            w_cap[i] = w_move[i-1] && !w_kill[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < STAGES; i++)
                r_data[i] <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                r_valid[i] <= !w_kill[i] && (w_cap[i] || (r_valid[i] && !w_move[i]));
                if (w_cap[i])
                    r_data[i] <= w_src[i];
            end
        end
    end

    always_comb begin
        stage_data = '0;
        for (int i = 0; i < STAGES; i++)
            stage_data[i*W +: W] = r_data[i];
    end

    assign in_ready    = w_ready[0];
    assign out_valid   = r_valid[STAGES-1];
    assign out_data    = r_data[STAGES-1];
    assign stage_valid = r_valid;

`ifdef PIPE_CHAIN_PERF_EN
    logic [CNT_W-1:0] r_cnt_ret, r_cnt_bub, r_cnt_fl;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_ret <= '0;
            r_cnt_bub <= '0;
            r_cnt_fl  <= '0;
        end else begin
            if (w_move[STAGES-1] && r_cnt_ret != '1)
                r_cnt_ret <= r_cnt_ret + 1'b1;
            if (out_ready && !r_valid[STAGES-1] && r_cnt_bub != '1)
                r_cnt_bub <= r_cnt_bub + 1'b1;
            if (|flush_req && r_cnt_fl != '1)
                r_cnt_fl <= r_cnt_fl + 1'b1;
        end
    end

    assign cnt_retired = r_cnt_ret;
    assign cnt_bubble  = r_cnt_bub;
    assign cnt_flush   = r_cnt_fl;
`else
    assign cnt_retired = '0;
    assign cnt_bubble  = '0;
    assign cnt_flush   = '0;
`endif
endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: directed table, hand sequences and random stimulus against a stage-array model.
module tb_pipe_chain;
    localparam int W  = 8;
    localparam int S  = 5;
    localparam int CW = 4;
`ifdef PIPE_CHAIN_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
    logic [S-1:0] stall_req, flush_req, stage_valid;
    logic [S*W-1:0] stage_data;
    logic [CW-1:0] cnt_retired, cnt_bubble, cnt_flush;

    int n_chk = 0;
    int n_fail = 0;

    bit m_v[S];
    logic [W-1:0] m_d[S];
    bit m_mov[S];
    bit m_rdy[S];
    int m_ret, m_bub, m_fl;
    logic s_in_ready, s_out_valid;
    logic [W-1:0] s_out_data;

    typedef struct {
        logic iv;
        logic [W-1:0] id;
        logic [S-1:0] st;
        logic [S-1:0] fl;
        logic ordy;
        logic er;
        logic [S-1:0] ev;
        logic [W-1:0] eo;
    } vec_t;
    vec_t tbl[13];

    pipe_chain #(.W(W), .STAGES(S), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .stall_req(stall_req), .flush_req(flush_req), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .stage_valid(stage_valid), .stage_data(stage_data),
        .cnt_retired(cnt_retired), .cnt_bubble(cnt_bubble), .cnt_flush(cnt_flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v == (1 << CW) - 1) ? v : v + 1;
    endfunction

    function automatic logic [S-1:0] m_vp();
        logic [S-1:0] r;
        for (int i = 0; i < S; i++) r[i] = m_v[i];
        return r;
    endfunction

    function automatic logic [S*W-1:0] m_dp();
        logic [S*W-1:0] r;
        for (int i = 0; i < S; i++) r[i*W +: W] = m_d[i];
        return r;
    endfunction

    // A stage can take a new item if not stalled and it is empty or its item leaves.
    task automatic mdl_comb();
        m_mov[S-1] = m_v[S-1] && out_ready && !stall_req[S-1];
        m_rdy[S-1] = !stall_req[S-1] && (!m_v[S-1] || m_mov[S-1]);
        for (int i = S-2; i >= 0; i--) begin
            m_mov[i] = m_v[i] && !stall_req[i] && m_rdy[i+1];
            m_rdy[i] = !stall_req[i] && (!m_v[i] || m_mov[i]);
        end
    endtask

    task automatic mdl_edge();
        int k;
        k = -1;
        if (rst) begin
            for (int i = 0; i < S; i++) begin
                m_v[i] = 1'b0;
                m_d[i] = '0;
            end
            m_ret = 0; m_bub = 0; m_fl = 0;
        end else begin
            for (int i = 0; i < S; i++) if (flush_req[i]) k = i;
            if (m_mov[S-1]) m_ret = sat(m_ret);
            if (out_ready && !m_v[S-1]) m_bub = sat(m_bub);
            if (k >= 0) m_fl = sat(m_fl);
            for (int i = S-1; i >= 1; i--) begin
                if (i <= k) m_v[i] = 1'b0;
                else if (m_mov[i-1]) begin
                    if (i-1 <= k) m_v[i] = 1'b0;
                    else begin
                        m_v[i] = 1'b1;
                        m_d[i] = m_d[i-1];
                    end
                end else if (m_mov[i]) m_v[i] = 1'b0;
            end
            if (k >= 0) m_v[0] = 1'b0;
            else if (in_valid && m_rdy[0]) begin
                m_v[0] = 1'b1;
                m_d[0] = in_data;
            end else if (m_mov[0]) m_v[0] = 1'b0;
        end
    endtask

    task automatic tick(input bit full);
        mdl_comb();
        @(negedge clk);
        s_in_ready = in_ready;
        s_out_valid = out_valid;
        s_out_data = out_data;
        if (full) begin
            chk("in_ready", 64'(in_ready), 64'(m_rdy[0]));
            chk("out_valid", 64'(out_valid), 64'(m_v[S-1]));
            chk("out_data", 64'(out_data), 64'(m_d[S-1]));
        end
        @(posedge clk);
        mdl_edge();
        #1;
        if (full) begin
            chk("stage_valid", 64'(stage_valid), 64'(m_vp()));
            chk("stage_data", 64'(stage_data), 64'(m_dp()));
            chk("cnt_retired", 64'(cnt_retired), PERF ? 64'(m_ret) : 64'd0);
            chk("cnt_bubble", 64'(cnt_bubble), PERF ? 64'(m_bub) : 64'd0);
            chk("cnt_flush", 64'(cnt_flush), PERF ? 64'(m_fl) : 64'd0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; stall_req = '0; flush_req = '0; out_ready = 1'b1;
        tick(0);
        rst = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data = d;
        tick(0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'h11, 5'b0, 5'b0, 1'b1, 1'b1, 5'b00001, 8'h00};
        tbl[1]  = '{1'b1, 8'h12, 5'b0, 5'b0, 1'b1, 1'b1, 5'b00011, 8'h00};
        tbl[2]  = '{1'b1, 8'h13, 5'b0, 5'b0, 1'b1, 1'b1, 5'b00111, 8'h00};
        tbl[3]  = '{1'b1, 8'h14, 5'b0, 5'b0, 1'b1, 1'b1, 5'b01111, 8'h00};
        tbl[4]  = '{1'b1, 8'h15, 5'b0, 5'b0, 1'b1, 1'b1, 5'b11111, 8'h11};
        tbl[5]  = '{1'b1, 8'h16, 5'b0, 5'b0, 1'b1, 1'b1, 5'b11111, 8'h12};
        tbl[6]  = '{1'b1, 8'h17, 5'b0, 5'b0, 1'b1, 1'b1, 5'b11111, 8'h13};
        tbl[7]  = '{1'b1, 8'h18, 5'b0, 5'b0, 1'b1, 1'b1, 5'b11111, 8'h14};
        tbl[8]  = '{1'b0, 8'h00, 5'b0, 5'b0, 1'b1, 1'b1, 5'b11110, 8'h15};
        tbl[9]  = '{1'b0, 8'h00, 5'b0, 5'b0, 1'b1, 1'b1, 5'b11100, 8'h16};
        tbl[10] = '{1'b0, 8'h00, 5'b0, 5'b0, 1'b1, 1'b1, 5'b11000, 8'h17};
        tbl[11] = '{1'b0, 8'h00, 5'b0, 5'b0, 1'b1, 1'b1, 5'b10000, 8'h18};
        tbl[12] = '{1'b0, 8'h00, 5'b0, 5'b0, 1'b1, 1'b1, 5'b00000, 8'h18};

        in_data = '0;
        do_reset();
        chk("rst_stage_valid", 64'(stage_valid), 64'd0);
        chk("rst_stage_data", 64'(stage_data), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_cnt_retired", 64'(cnt_retired), 64'd0);

        for (int r = 0; r < 13; r++) begin
            in_valid = tbl[r].iv; in_data = tbl[r].id; stall_req = tbl[r].st;
            flush_req = tbl[r].fl; out_ready = tbl[r].ordy;
            tick(0);
            chk($sformatf("tbl%0d_in_ready", r), 64'(s_in_ready), 64'(tbl[r].er));
            chk($sformatf("tbl%0d_valid", r), 64'(stage_valid), 64'(tbl[r].ev));
            chk($sformatf("tbl%0d_out", r), 64'(out_data), 64'(tbl[r].eo));
        end

        // Back-pressure: fill with the sink blocked, hold, then drain in order.
        do_reset();
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) push(8'hA0 + 8'(j));
        for (int j = 0; j < 3; j++) begin
            push(8'hA5);
            chk("bp_in_ready", 64'(s_in_ready), 64'd0);
            chk("bp_hold_data", 64'(stage_data), 64'hA0A1A2A3A4);
            chk("bp_hold_valid", 64'(stage_valid), 64'h1F);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick(0);
            if (j == 0) chk("bp_release_ready", 64'(s_in_ready), 64'd1);
            chk("bp_drain_valid", 64'(s_out_valid), 64'd1);
            chk("bp_drain_data", 64'(s_out_data), 64'(8'hA0 + 8'(j)));
        end
        chk("bp_empty", 64'(stage_valid), 64'd0);

        // Middle-stage stall.
        do_reset();
        for (int j = 0; j < 5; j++) push(8'hB0 + 8'(j));
        stall_req = 5'b00100;
        push(8'hB5);
        chk("st1_in_ready", 64'(s_in_ready), 64'd0);
        chk("st1_valid", 64'(stage_valid), 64'b10111);
        chk("st1_out", 64'(out_data), 64'hB1);
        push(8'hB6);
        chk("st2_in_ready", 64'(s_in_ready), 64'd0);
        chk("st2_valid", 64'(stage_valid), 64'b00111);
        chk("st2_hold", 64'(stage_data[23:16]), 64'hB2);
        stall_req = '0; in_valid = 1'b0;
        tick(0);
        chk("st3_in_ready", 64'(s_in_ready), 64'd1);
        chk("st3_valid", 64'(stage_valid), 64'b01110);

        // Flush of stages 0..2 with a full pipe.
        do_reset();
        for (int j = 0; j < 5; j++) push(8'hC0 + 8'(j));
        flush_req = 5'b00100;
        push(8'hCF);
        flush_req = '0; in_valid = 1'b0;
        chk("fl_valid", 64'(stage_valid), 64'b10000);
        chk("fl_out", 64'(out_data), 64'hC1);
        chk("fl_data", 64'(stage_data), 64'hC1C1C2C3C4);
        chk("fl_cnt", 64'(cnt_flush), PERF ? 64'd1 : 64'd0);

        // Reset overriding flush/stall mid-stream.
        do_reset();
        for (int j = 0; j < 3; j++) push(8'hD0 + 8'(j));
        rst = 1'b1; flush_req = 5'h1F; stall_req = 5'h1F; in_valid = 1'b1;
        tick(0);
        rst = 1'b0; flush_req = '0; stall_req = '0; in_valid = 1'b0;
        #1;
        chk("mr_valid", 64'(stage_valid), 64'd0);
        chk("mr_data", 64'(stage_data), 64'd0);
        chk("mr_cnt", 64'({cnt_retired, cnt_bubble, cnt_flush}), 64'd0);
        chk("mr_in_ready", 64'(in_ready), 64'd1);
        chk("mr_out_valid", 64'(out_valid), 64'd0);

        // Counter saturation with 20 retirements.
        do_reset();
        for (int j = 0; j < 20; j++) push(8'(j));
        in_valid = 1'b0;
        for (int j = 0; j < 6; j++) tick(0);
        chk("sat_retired", 64'(cnt_retired), PERF ? 64'd15 : 64'd0);

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(99) == 0);
            in_valid = ($urandom_range(9) < 7);
            in_data = W'($urandom);
            for (int b = 0; b < S; b++) stall_req[b] = ($urandom_range(7) == 0);
            flush_req = ($urandom_range(19) == 0) ? S'($urandom) : '0;
            out_ready = ($urandom_range(9) < 7);
            tick(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
